mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_select.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, default fairness/timeout limits, counter sizing.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam int MAX_D_STREAK_DEF = 4;
    localparam int TIMEOUT_DEF      = 255;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory signals of the arbiter.
// slave = arbiter side, master = CPU pipeline plus memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              err_o;
    logic              if_stall_o;
    logic              d_stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_ack_i, mem_rdata_i,
        output if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, err_o,
               if_stall_o, d_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, err_o,
               if_stall_o, d_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arb_select.sv
// Grant selection between fetch (I) and data (D) requesters: D wins ties
// until it has taken MAX_D_STREAK grants in a row while I was waiting.
module mem_arb_select
    import cpu_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic grant_en_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic grant_d_o
);
    localparam int              SW         = cnt_width(MAX_D_STREAK);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] d_streak_q;
    logic [SW-1:0] d_streak_d;
    logic          i_starved_s;

    assign i_starved_s = if_req_i & (d_streak_q == STREAK_MAX);
    assign grant_d_o   = d_req_i & ~i_starved_s;

    // Streak only grows for D grants that made a waiting I stand aside.
    always_comb begin
        d_streak_d = d_streak_q;
        if (grant_en_i) begin
            if (grant_d_o && if_req_i) begin
                if (d_streak_q != STREAK_MAX) begin
                    d_streak_d = d_streak_q + SW'(1);
                end else begin
                    d_streak_d = d_streak_q;
                end
            end else begin
                d_streak_d = '0;
            end
        end else begin
            d_streak_d = d_streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_streak_q <= '0;
        end else begin
            d_streak_q <= d_streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and
// data access: IDLE -> BUSY_I/BUSY_D -> RESP, with a bounded wait per access.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int               CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W:0]   TIMEOUT_V = (CNT_W + 1)'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              any_req_s;
    logic              grant_en_s;
    logic              grant_d_s;
    logic              busy_s;
    logic [CNT_W:0]    busy_cycles_s;
    logic              timeout_s;

    assign any_req_s     = bus.if_req_i | bus.d_req_i;
    assign grant_en_s    = (state_q == ST_IDLE) & any_req_s;
    assign busy_s        = (state_q == ST_BUSY_I) | (state_q == ST_BUSY_D);
    // Count includes the current BUSY cycle, so the limit is exactly TIMEOUT cycles.
    assign busy_cycles_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_s     = (busy_cycles_s >= TIMEOUT_V);

    mem_arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_select (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .grant_en_i (grant_en_s),
        .if_req_i   (bus.if_req_i),
        .d_req_i    (bus.d_req_i),
        .grant_d_o  (grant_d_s)
    );

    // Next-state, request latching, completion capture and timeout counting.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = grant_d_s ? ST_BUSY_D : ST_BUSY_I;
                    addr_d  = grant_d_s ? bus.d_addr_i : bus.if_addr_i;
                    we_d    = grant_d_s & bus.d_we_i;
                    wdata_d = grant_d_s ? bus.d_wdata_i : '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.mem_ack_i || timeout_s) begin
                    state_d = ST_RESP;
                    err_d   = ~bus.mem_ack_i;
                    if (state_q == ST_BUSY_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_ack_i ? bus.mem_rdata_i : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = bus.mem_ack_i ? bus.mem_rdata_i : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.mem_req_o   = busy_s;
    assign bus.mem_we_o    = (state_q == ST_BUSY_D) & we_q;
    assign bus.mem_addr_o  = busy_s ? addr_q : '0;
    assign bus.mem_wdata_o = busy_s ? wdata_q : '0;

    assign bus.if_ack_o   = if_ack_q;
    assign bus.d_ack_o    = d_ack_q;
    assign bus.err_o      = err_q;
    assign bus.if_rdata_o = if_rdata_q;
    assign bus.d_rdata_o  = d_rdata_q;
    assign bus.if_stall_o = bus.if_req_i & ~if_ack_q;
    assign bus.d_stall_o  = bus.d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes requests and expected completions in
// grant order; a negedge monitor checks grants, memory side and acks.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int TMO = TIMEOUT_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dop_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        bit          err;
        int          busy_len;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] iq[$];
    dop_t        dq[$];

    int tests = 0;
    int fails = 0;
    int mem_lat = 0;
    bit mem_silent = 1'b0;
    bit spurious = 1'b0;
    bit scramble = 1'b0;

    int          busy_cnt = 0;
    int          wait_cnt = 0;
    bit          prev_req = 1'b0;
    logic [31:0] last_if = 32'h0;
    logic [31:0] last_d = 32'h0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic exp_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] data,
                                input bit err, input int busy_len);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata;
        e.data = data; e.err = err; e.busy_len = busy_len;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_i(input logic [31:0] a, input int lat);
        iq.push_back(a);
        exp_q.push_back(mk(1'b0, 1'b0, a, 32'h0, mem_val(a), 1'b0, lat + 1));
    endtask

    task automatic push_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input int lat);
        dop_t op;
        op.we = we; op.addr = a; op.wdata = wd;
        dq.push_back(op);
        exp_q.push_back(mk(1'b1, we, a, wd, mem_val(a), 1'b0, lat + 1));
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && iq.size() == 0 && dq.size() == 0 &&
                 !bus.if_req_i && !bus.d_req_i) && n < bound) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= bound) begin
            fails++;
            $display("FAIL drain_timeout: %0d expectations left after %0d cycles", exp_q.size(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Fetch requester: holds the request until its ack, then takes the next one.
    initial begin
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.if_req_i = 1'b0;
            end else if (bus.if_ack_o || !bus.if_req_i) begin
                if (iq.size() > 0) begin
                    bus.if_addr_i = iq.pop_front();
                    bus.if_req_i  = 1'b1;
                end else begin
                    bus.if_req_i = 1'b0;
                end
            end
        end
    end

    // Data requester; with scramble set it garbles its inputs while the access is in flight.
    initial begin
        dop_t op;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
        bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.d_req_i = 1'b0;
            end else if (bus.d_ack_o || !bus.d_req_i) begin
                if (dq.size() > 0) begin
                    op = dq.pop_front();
                    bus.d_req_i = 1'b1; bus.d_we_i = op.we;
                    bus.d_addr_i = op.addr; bus.d_wdata_i = op.wdata;
                end else begin
                    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
                end
            end else if (scramble && bus.mem_req_o) begin
                bus.d_addr_i  = ~bus.d_addr_i;
                bus.d_wdata_i = ~bus.d_wdata_i;
                bus.d_we_i    = ~bus.d_we_i;
            end
        end
    end

    // Memory model: acks after mem_lat extra BUSY cycles.
    initial begin
        int bcnt = 0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.mem_ack_i = 1'b0; bcnt = 0;
            end else if (bus.mem_req_o) begin
                bus.mem_ack_i   = !mem_silent && (bcnt == mem_lat);
                bus.mem_rdata_i = bus.mem_ack_i ? mem_val(bus.mem_addr_o) : 32'hBAD0_BAD0;
                bcnt++;
            end else begin
                bus.mem_ack_i   = spurious;
                bus.mem_rdata_i = 32'hBAD0_BAD0;
                bcnt = 0;
            end
        end
    end

    // Monitor and scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0; wait_cnt = 0; prev_req = 1'b0;
                last_if = 32'h0; last_d = 32'h0;
            end else begin
                chk("if_stall", 32'(bus.if_stall_o), 32'(bus.if_req_i & ~bus.if_ack_o));
                chk("d_stall", 32'(bus.d_stall_o), 32'(bus.d_req_i & ~bus.d_ack_o));
                if (bus.mem_req_o) begin
                    if (!prev_req) begin
                        chk("grant_wait", 32'(wait_cnt), 32'd1);
                        wait_cnt = 0;
                    end
                    busy_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 32'd1, 32'd0);
                    end else begin
                        chk("mem_we", 32'(bus.mem_we_o), 32'(exp_q[0].we));
                        chk("mem_addr", bus.mem_addr_o, exp_q[0].addr);
                        chk("mem_wdata", bus.mem_wdata_o, exp_q[0].wdata);
                    end
                end
                if (bus.if_ack_o || bus.d_ack_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", {30'h0, bus.d_ack_o, bus.if_ack_o}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_side", {30'h0, bus.d_ack_o, bus.if_ack_o}, e.is_d ? 32'h2 : 32'h1);
                        chk("rdata", e.is_d ? bus.d_rdata_o : bus.if_rdata_o, e.data);
                        chk("other_rdata_hold", e.is_d ? bus.if_rdata_o : bus.d_rdata_o,
                            e.is_d ? last_if : last_d);
                        chk("err", 32'(bus.err_o), 32'(e.err));
                        chk("busy_len", prev_req ? 32'(busy_cnt) : 32'hFFFF_FFFF, 32'(e.busy_len));
                        chk("mem_idle_in_resp", {bus.mem_addr_o[15:0], bus.mem_wdata_o[13:0],
                            bus.mem_req_o, bus.mem_we_o}, 32'h0);
                        if (e.is_d) last_d = e.data; else last_if = e.data;
                    end
                    busy_cnt = 0; wait_cnt = 0;
                end else begin
                    if (bus.err_o) chk("err_without_ack", 32'd1, 32'd0);
                    if (!bus.mem_req_o && (bus.if_req_i || bus.d_req_i)) wait_cnt++;
                end
                prev_req = bus.mem_req_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_acks", {29'h0, bus.err_o, bus.d_ack_o, bus.if_ack_o}, 32'h0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_d_rdata", bus.d_rdata_o, 32'h0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);

        // Single fetch, two extra wait cycles.
        mem_lat = 2;
        push_i(32'h10, 2);
        drain(50);

        // Simultaneous fetch and store: D first, then I.
        mem_lat = 0;
        push_d(1'b1, 32'h20, 32'h5, 0);
        push_i(32'h40, 0);
        drain(50);

        // Continuous D with I pending: D,D,D,D,I,D.
        mem_lat = 1;
        push_d(1'b0, 32'h200, 32'h0, 1);
        push_d(1'b1, 32'h204, 32'h11, 1);
        push_d(1'b0, 32'h208, 32'h0, 1);
        push_d(1'b1, 32'h20C, 32'h22, 1);
        push_i(32'h100, 1);
        push_d(1'b0, 32'h210, 32'h0, 1);
        dq.push_back('{1'b0, 32'h200, 32'h0});
        dq.push_back('{1'b1, 32'h204, 32'h11});
        dq.push_back('{1'b0, 32'h208, 32'h0});
        dq.push_back('{1'b1, 32'h20C, 32'h22});
        dq.push_back('{1'b0, 32'h210, 32'h0});
        repeat (5) void'(dq.pop_front());
        drain(100);

        // Inputs change while the access is in flight.
        mem_lat = 3; scramble = 1'b1;
        push_d(1'b0, 32'h300, 32'h0, 3);
        drain(50);
        scramble = 1'b0;

        // Memory never answers: timeout error.
        mem_silent = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, TMO));
        dq.push_back('{1'b0, 32'h400, 32'h0});
        drain(TMO + 50);
        mem_silent = 1'b0;

        // Ack in the same cycle as the timeout wins, no error.
        mem_lat = TMO - 1;
        push_i(32'h500, TMO - 1);
        drain(TMO + 50);

        // Spurious memory ack while idle.
        spurious = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_mem_req", 32'(bus.mem_req_o), 32'h0);
            chk("spurious_acks", {30'h0, bus.d_ack_o, bus.if_ack_o}, 32'h0);
        end
        spurious = 1'b0;
        mem_lat = 0;
        push_i(32'h700, 0);
        drain(50);

        // Reset in the middle of a data access.
        mem_silent = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h600, 32'h33, 32'h0, 1'b0, 0));
        dq.push_back('{1'b1, 32'h600, 32'h33});
        n = 0;
        while (!bus.mem_req_o && n < 20) begin @(negedge clk); n++; end
        chk("rst_test_grant", 32'(bus.mem_req_o), 32'h1);
        repeat (3) @(negedge clk);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("midrst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("midrst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("midrst_d_ack", {31'h0, bus.d_ack_o}, 32'h0);
        chk("midrst_d_rdata", bus.d_rdata_o, 32'h0);
        void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        mem_silent = 1'b0; mem_lat = 1;
        @(negedge clk);
        push_d(1'b1, 32'h640, 32'h77, 1);
        drain(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
